// File: rtl/pattern_tx_1010.sv
// Serial pattern transmitter: sends PATTERN (MSB first) rep_cnt times,
// with an optional idle gap between repetitions, then pulses done.
module pattern_tx_1010 #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [2:0]       gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int               BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(PAT_W - 1);
  // The MSB is driven straight onto out when a repetition starts, so the
  // shift register only ever holds the bits still to be sent.
  localparam logic [PAT_W-1:0] PAT_REST = PATTERN << 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state;
  logic [PAT_W-1:0] shreg;
  logic [BIT_W-1:0] bits_left;
  logic [CNT_W-1:0] reps_left;
  logic [2:0]       gap_len;
  logic [2:0]       gap_left;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bits_left <= '0;
      reps_left <= '0;
      gap_len   <= '0;
      gap_left  <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (start && rep_cnt != '0) begin
            state     <= SEND;
            reps_left <= rep_cnt;
            gap_len   <= gap;
            shreg     <= PAT_REST;
            bits_left <= LAST_IDX;
            out       <= PATTERN[PAT_W-1];
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end

        SEND: begin
          if (bits_left != '0) begin
            out       <= shreg[PAT_W-1];
            shreg     <= shreg << 1;
            bits_left <= bits_left - 1'b1;
          end else begin
            reps_left <= reps_left - 1'b1;
            // The last repetition never gets a trailing gap.
            if (reps_left == CNT_W'(1)) begin
              state     <= DONE;
              out       <= 1'b0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (gap_len != '0) begin
              state     <= GAP;
              gap_left  <= gap_len - 1'b1;
              out       <= 1'b0;
              out_valid <= 1'b0;
            end else begin
              shreg     <= PAT_REST;
              bits_left <= LAST_IDX;
              out       <= PATTERN[PAT_W-1];
            end
          end
        end

        GAP: begin
          if (gap_left == '0) begin
            state     <= SEND;
            shreg     <= PAT_REST;
            bits_left <= LAST_IDX;
            out       <= PATTERN[PAT_W-1];
            out_valid <= 1'b1;
          end else begin
            gap_left <= gap_left - 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_tx_1010.sv
// Directed bench for pattern_tx_1010: each cycle of every burst is checked
// against a per-cycle expected {out, out_valid, busy, done} vector.
module tb_pattern_tx_1010;

  localparam logic [3:0] PAT = 4'b1010;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       start   = 1'b0;
  logic [3:0] rep_cnt = 4'd0;
  logic [2:0] gap     = 3'd0;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int hits   = 0;
  logic [1:0] det = 2'd0;

  pattern_tx_1010 #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rep_cnt   (rep_cnt),
    .gap       (gap),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Non-overlapping Mealy 1010 detector listening to the serial line.
  always @(negedge clk) begin
    case (det)
      2'd0: det <= out ? 2'd1 : 2'd0;
      2'd1: det <= out ? 2'd1 : 2'd2;
      2'd2: det <= out ? 2'd3 : 2'd0;
      default: begin
        if (!out) begin
          hits <= hits + 1;
          det  <= 2'd0;
        end else begin
          det <= 2'd1;
        end
      end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({out, out_valid, busy, done});
  endfunction

  // Runs one burst, pulsing a bogus start at cycle 'mid' (negative = never),
  // and leaves the bench on the first IDLE cycle plus 'trail'-1 more.
  task automatic burst(input int rep, input int gp, input int mid, input int trail, input string name);
    int cyc = 0;
    int busy_seen = 0;
    start   = 1'b1;
    rep_cnt = 4'(rep);
    gap     = 3'(gp);
    step();
    start   = 1'b0;
    rep_cnt = 4'(rep + 3);
    gap     = 3'(gp + 5);
    for (int r = 0; r < rep; r++) begin
      for (int b = 0; b < 4; b++) begin
        chk($sformatf("%s r%0d b%0d", name, r, b), outs(), 32'({PAT[3-b], 3'b110}));
        busy_seen += int'(busy);
        start = (cyc == mid);
        step();
        cyc++;
      end
      if (r < rep - 1) begin
        for (int g = 0; g < gp; g++) begin
          chk($sformatf("%s r%0d gap%0d", name, r, g), outs(), 32'b0010);
          busy_seen += int'(busy);
          start = (cyc == mid);
          step();
          cyc++;
        end
      end
    end
    start = 1'b0;
    chk($sformatf("%s done", name), outs(), 32'b0001);
    step();
    chk($sformatf("%s idle0", name), outs(), 32'b0000);
    for (int t = 1; t < trail; t++) begin
      step();
      chk($sformatf("%s idle%0d", name, t), outs(), 32'b0000);
    end
    chk($sformatf("%s busy_len", name), 32'(busy_seen), 32'(rep * 4 + (rep - 1) * gp));
  endtask

  initial begin
    int h0;

    #2 rst = 1'b0;
    #1 chk("reset_async", outs(), 32'b0000);
    step();
    step();
    chk("reset_held", outs(), 32'b0000);
    rst = 1'b1;
    step();
    chk("reset_release0", outs(), 32'b0000);
    step();
    chk("reset_release1", outs(), 32'b0000);

    start   = 1'b1;
    rep_cnt = 4'd0;
    gap     = 3'd2;
    step();
    chk("zero_rep0", outs(), 32'b0000);
    step();
    chk("zero_rep1", outs(), 32'b0000);
    start = 1'b0;
    step();
    chk("zero_rep2", outs(), 32'b0000);

    burst(1, 0, -1, 1, "single");
    burst(3, 0, 5, 1, "b2b");
    burst(2, 2, 3, 3, "gapped");

    h0 = hits;
    burst(5, 1, -1, 2, "loop");
    chk("loop_hits", 32'(hits - h0), 32'd5);

    burst(15, 0, -1, 1, "max");

    start   = 1'b1;
    rep_cnt = 4'd5;
    gap     = 3'd1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("abort_pre", outs(), 32'b0110);
    #2 rst = 1'b0;
    #1 chk("abort_async", outs(), 32'b0000);
    step();
    chk("abort_held0", outs(), 32'b0000);
    step();
    chk("abort_held1", outs(), 32'b0000);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("abort_idle%0d", i), outs(), 32'b0000);
    end

    burst(1, 3, -1, 2, "recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
